// File: rtl/wfi_wake_ctrl.sv
// WFI sleep/wake controller: parks the pipeline on a retiring WFI until an enabled interrupt is pending.
// Optional build macro WFI_TIMEOUT_EN adds a bounded-sleep counter with timeout_cycles/timed_out ports.
module wfi_wake_ctrl #(
  parameter int NUM_IRQ       = 4,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int CAUSE_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wfi_valid,
  output logic                     wfi_ready,
  input  logic                     flush,
  input  logic [NUM_IRQ-1:0]       irq_pending,
  input  logic [NUM_IRQ-1:0]       irq_enable,
  input  logic                     global_ie,
  output logic                     stall,
  output logic                     sleeping,
  output logic                     wake,
  output logic                     wake_is_irq,
`ifdef WFI_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic                     timed_out,
`endif
  output logic [CAUSE_W-1:0]       wake_cause
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SLEEP = 2'b01,
    WAKE  = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 hit_s;
  logic                 timeout_wake_s;
  logic [NUM_IRQ-1:0]   active_s;
  logic [CAUSE_W-1:0]   wake_cause_r;
  logic                 wake_is_irq_r;
  logic                 timed_out_r;

  // Lowest set bit wins: scan downward so the last assignment is the smallest index.
  function automatic logic [CAUSE_W-1:0] lowest_index(input logic [NUM_IRQ-1:0] vec);
    logic [CAUSE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CAUSE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign active_s = irq_pending & irq_enable;
  assign hit_s    = |active_s;

`ifdef WFI_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] count_r;
  logic                     count_expired_s;

  assign count_expired_s = (count_r == TIMEOUT_WIDTH'(1));

  // Sleep bound counter; a zero load never reaches 1, so sleep is unbounded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (!flush && (state_r == IDLE) && (state_s == SLEEP)) begin
      count_r <= timeout_cycles;
    end else if ((state_r == SLEEP) && (count_r != '0)) begin
      count_r <= count_r - TIMEOUT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end
`else
  logic count_expired_s;
  assign count_expired_s = 1'b0;
`endif

  // Next-state decode; flush overrides every other condition.
  always_comb begin
    state_s        = state_r;
    timeout_wake_s = 1'b0;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (wfi_valid) begin
            state_s = hit_s ? WAKE : SLEEP;
          end else begin
            state_s = IDLE;
          end
        end
        SLEEP: begin
          if (hit_s) begin
            state_s = WAKE;
          end else if (count_expired_s) begin
            state_s        = WAKE;
            timeout_wake_s = 1'b1;
          end else begin
            state_s = SLEEP;
          end
        end
        WAKE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Wake report is captured only on entry to WAKE and held until the next entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wake_cause_r  <= '0;
      wake_is_irq_r <= 1'b0;
      timed_out_r   <= 1'b0;
    end else if (state_s == WAKE) begin
      wake_cause_r  <= lowest_index(active_s);
      wake_is_irq_r <= global_ie & ~timeout_wake_s;
      timed_out_r   <= timeout_wake_s;
    end else begin
      wake_cause_r  <= wake_cause_r;
      wake_is_irq_r <= wake_is_irq_r;
      timed_out_r   <= timed_out_r;
    end
  end

  assign wfi_ready   = (state_r == IDLE);
  assign stall       = (state_r != IDLE);
  assign sleeping    = (state_r == SLEEP);
  assign wake        = (state_r == WAKE);
  assign wake_is_irq = wake_is_irq_r;
  assign wake_cause  = wake_cause_r;

`ifdef WFI_TIMEOUT_EN
  assign timed_out = timed_out_r;
`else
  logic unused_timed_out_s;
  assign unused_timed_out_s = timed_out_r;
`endif

endmodule
